slice_checker: RTL and testbench

SLICE_CHECKER -- requirements
Module: slice_checker

---
 rtl/slice_checker.sv | 150 +++++++++++++++
 tb/tb_slice_checker.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/slice_checker.sv
`timescale 1ns/1ps
// Checks a bit-reversing slice stage: captures in_vec, waits SETTLE cycles, compares dut_vec 4-state exact.
// Latency: SETTLE+1 cycles capture-to-compare; err_pulse in CMP, err_count/bad_* visible the cycle after.
// No backpressure: upstream spaces vectors >= SETTLE+2 apart; define SLICE_CHECKER_DISPLAY_EN for text reports.

module slice_checker #(
    parameter int WIDTH   = 8,
    parameter int SAMPLES = 20000,
    parameter int SETTLE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_vec,
    input  logic [WIDTH-1:0] dut_vec,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] bad_in,
    output logic [WIDTH-1:0] bad_out
);
    localparam int             SCW       = $clog2(SAMPLES + 1);
    localparam logic [3:0]     SETTLE_LD = 4'(SETTLE - 1);
    localparam logic [SCW-1:0] SAMPLES_C = SCW'(SAMPLES);

    typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_SETTLE, ST_CMP, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] in_q, in_d;
    logic [WIDTH-1:0] bad_in_q, bad_in_d;
    logic [WIDTH-1:0] bad_out_q, bad_out_d;
    logic [WIDTH-1:0] in_rev;
    logic [3:0]       settle_q, settle_d;
    logic [SCW-1:0]   smp_q, smp_d;
    logic [15:0]      err_count_q, err_count_d;
    logic             mismatch;

    always_comb begin
        in_rev = '0;
        for (int k = 0; k < WIDTH; k++) begin
            in_rev[k] = in_vec[WIDTH-1-k];
        end
    end

    // Case-inequality: an X or Z bit in the expected value only matches the same X or Z.
    assign mismatch = (dut_vec !== exp_q);

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        in_d        = in_q;
        bad_in_d    = bad_in_q;
        bad_out_d   = bad_out_q;
        settle_d    = settle_q;
        smp_d       = smp_q;
        err_count_d = err_count_q;
        err_pulse   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_ARM;
                    err_count_d = '0;
                    smp_d       = '0;
                end
            end
            ST_ARM: begin
                if (in_valid) begin
                    exp_d    = in_rev;
                    in_d     = in_vec;
                    settle_d = SETTLE_LD;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // A fresh vector restarts the settle window and replaces the pending sample.
                if (in_valid) begin
                    exp_d    = in_rev;
                    in_d     = in_vec;
                    settle_d = SETTLE_LD;
                end else if (settle_q == 4'd0) begin
                    state_d = ST_CMP;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            ST_CMP: begin
                if (mismatch) begin
                    err_pulse = 1'b1;
                    bad_in_d  = in_q;
                    bad_out_d = dut_vec;
                    if (err_count_q != 16'hFFFF) begin
                        err_count_d = err_count_q + 16'd1;
                    end
                end
                smp_d   = smp_q + SCW'(1);
                state_d = (smp_d == SAMPLES_C) ? ST_DONE : ST_ARM;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            exp_q       <= '0;
            in_q        <= '0;
            bad_in_q    <= '0;
            bad_out_q   <= '0;
            settle_q    <= '0;
            smp_q       <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            in_q        <= in_d;
            bad_in_q    <= bad_in_d;
            bad_out_q   <= bad_out_d;
            settle_q    <= settle_d;
            smp_q       <= smp_d;
            err_count_q <= err_count_d;
        end
    end

    assign busy      = (state_q == ST_ARM) || (state_q == ST_SETTLE) || (state_q == ST_CMP);
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (err_count_q == 16'd0);
    assign err_count = err_count_q;
    assign bad_in    = bad_in_q;
    assign bad_out   = bad_out_q;

`ifdef SLICE_CHECKER_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (rst_n && state_q == ST_CMP) begin
            if (mismatch) begin
                $display("slice_checker: OUTPUT %b INPUT %b CORRECT %b", dut_vec, in_q, exp_q);
            end
            if (state_d == ST_DONE) begin
                if (err_count_d == 16'd0) $display("PASSED");
                else                      $display("FAILED %0d", err_count_d);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_slice_checker.sv
`timescale 1ns/1ps
// Directed bench for slice_checker (WIDTH=8, SAMPLES=4, SETTLE=3) with a scoreboard of expected compares.

module tb_slice_checker;
    localparam int W  = 8;
    localparam int NS = 4;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_vec = '0;
    logic [W-1:0] dut_vec = '0;
    logic         busy, done, pass, err_pulse;
    logic [15:0]  err_count;
    logic [W-1:0] bad_in, bad_out;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] m_err  = '0;
    int          m_smp  = 0;

    typedef struct {
        logic         mm;
        logic [W-1:0] iv;
        logic [W-1:0] ov;
    } sb_t;
    sb_t sb[$];

    slice_checker #(.WIDTH(W), .SAMPLES(NS), .SETTLE(ST)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_vec(in_vec), .dut_vec(dut_vec), .busy(busy), .done(done),
        .pass(pass), .err_pulse(err_pulse), .err_count(err_count),
        .bad_in(bad_in), .bad_out(bad_out)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int k = 0; k < W; k++) r[k] = v[W-1-k];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left on a falling edge; leaves the DUT in ARM.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_err = '0;
        m_smp = 0;
        check("start_busy", busy, 1);
        check("start_done", done, 0);
        check("start_pass", pass, 0);
    endtask

    // Optionally sends a superseded vector v0 first; st_pulse raises start mid-run.
    task automatic send(input logic [W-1:0] v, input logic [W-1:0] d,
                        input bit sup, input logic [W-1:0] v0, input bit st_pulse);
        sb_t e;
        int  early;
        e.mm = (d !== rev(v));
        e.iv = v;
        e.ov = d;
        sb.push_back(e);
        if (sup) begin
            in_valid = 1'b1; in_vec = v0; dut_vec = d;
            @(negedge clk);
        end
        in_valid = 1'b1; in_vec = v; dut_vec = d;
        @(negedge clk);
        in_valid = 1'b0;
        if (st_pulse) start = 1'b1;
        early = 0;
        for (int k = 0; k < ST; k++) begin
            if (err_pulse !== 1'b0) early++;
            @(negedge clk);
            start = 1'b0;
        end
        e = sb.pop_front();
        check("no_early_pulse", early, 0);
        check("cmp_busy", busy, 1);
        check("cmp_err_pulse", err_pulse, e.mm);
        if (e.mm) begin
            m_err = (m_err == 16'hFFFF) ? m_err : m_err + 16'd1;
        end
        m_smp++;
        @(negedge clk);
        check("pulse_one_cycle", err_pulse, 0);
        check("err_count", err_count, m_err);
        if (e.mm) begin
            check("bad_in", bad_in, e.iv);
            check("bad_out", bad_out, e.ov);
        end
        check("done_after_cmp", done, m_smp == NS);
        check("busy_after_cmp", busy, m_smp != NS);
        if (m_smp == NS) check("pass_at_done", pass, m_err == 16'd0);
    endtask

    initial begin
        logic [W-1:0] pat[4];
        logic [W-1:0] xv;
        int           bad;
        pat = '{8'h01, 8'h80, 8'hA5, 8'h3C};
        xv  = 8'b1x00_0000;

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_count", err_count, 0);
        check("rst_bad_in", bad_in, 0);
        check("rst_bad_out", bad_out, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Clean run: reversed outputs everywhere.
        do_start();
        for (int i = 0; i < 4; i++) send(pat[i], rev(pat[i]), 1'b0, '0, 1'b0);
        check("run1_done", done, 1);
        check("run1_pass", pass, 1);
        check("run1_err_count", err_count, 0);

        // Mismatches, X handling, ignored start while busy, superseded sample.
        do_start();
        send(8'h01, 8'h01, 1'b0, '0, 1'b0);
        send(xv, 8'b0000_00x1, 1'b0, '0, 1'b1);
        send(xv, 8'b0000_0001, 1'b0, '0, 1'b0);
        send(8'hF0, 8'h0F, 1'b1, 8'h0F, 1'b0);
        check("run2_done", done, 1);
        check("run2_pass", pass, 0);

        // Asynchronous reset in the middle of a settle window.
        do_start();
        send(8'h55, 8'h00, 1'b0, '0, 1'b0);
        in_valid = 1'b1; in_vec = 8'h33; dut_vec = rev(8'h33);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_pass", pass, 0);
        check("arst_err_pulse", err_pulse, 0);
        check("arst_err_count", err_count, 0);
        check("arst_bad_in", bad_in, 0);
        check("arst_bad_out", bad_out, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_vec   = 8'($urandom);
            dut_vec  = 8'($urandom);
            @(negedge clk);
            if (busy !== 1'b0 || err_pulse !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        check("no_cmp_before_start", bad, 0);
        do_start();
        for (int i = 0; i < 4; i++) send(pat[3-i], rev(pat[3-i]), 1'b0, '0, 1'b0);
        check("run3_pass", pass, 1);

        // Saturation of the error counter.
        do_start();
        force dut.err_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.err_count_q;
        m_err = 16'hFFFE;
        send(8'h01, 8'h01, 1'b0, '0, 1'b0);
        send(8'h02, 8'h02, 1'b0, '0, 1'b0);
        send(8'h04, 8'h04, 1'b0, '0, 1'b0);
        send(8'h08, 8'h10, 1'b0, '0, 1'b0);
        check("sat_err_count", err_count, 16'hFFFF);
        check("sat_pass", pass, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
